// File: rtl/vpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : vpu_pkg
// Brief    : Opcode constants, unary-op helper and sequencer state encoding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vpu_pkg;

  localparam int VPU_OP_W = 10;

  localparam logic [VPU_OP_W-1:0] VPU_ADD    = 10'd0;
  localparam logic [VPU_OP_W-1:0] VPU_SUB    = 10'd1;
  localparam logic [VPU_OP_W-1:0] VPU_RELU   = 10'd2;
  localparam logic [VPU_OP_W-1:0] VPU_MUL    = 10'd3;
  localparam logic [VPU_OP_W-1:0] VPU_D_RELU = 10'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vpu_state_t;

  // Unary ops consume operand0 only; operand1 is neither read nor forwarded.
  function automatic logic is_unary(input logic [VPU_OP_W-1:0] opcode);
    return (opcode == VPU_RELU) || (opcode == VPU_D_RELU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vpu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : vpu_issue_ctrl
// Brief    : Streams one vector command through the VPU op unit, one element
//            per cycle: scratchpad read -> operand registers -> write back.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vpu_issue_ctrl
  import vpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 10,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_src0_addr,
  input  logic [ADDR_W-1:0] cmd_src1_addr,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  input  logic [LEN_W-1:0]  cmd_len,

  output logic              rd0_en,
  output logic [ADDR_W-1:0] rd0_addr,
  input  logic [DATA_W-1:0] rd0_data,
  output logic              rd1_en,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0] rd1_data,

  output logic              vpu_start,
  output logic [OP_W-1:0]   vpu_opcode,
  output logic [DATA_W-1:0] vpu_operand0,
  output logic [DATA_W-1:0] vpu_operand1,
  input  logic [DATA_W-1:0] vpu_result,

  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,

  output logic              busy,
  output logic              done
);

  vpu_state_t        r_state;
  logic [OP_W-1:0]   r_opcode;
  logic [ADDR_W-1:0] r_src0;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;

  // Two-stage valid/address pipe: stage 1 = read data arriving, stage 2 = operands held.
  logic              r_v1;
  logic              r_v2;
  logic [ADDR_W-1:0] r_wa1;
  logic [ADDR_W-1:0] r_wa2;
  logic [DATA_W-1:0] r_op0;
  logic [DATA_W-1:0] r_op1;

  logic              w_issue;
  logic              w_unary;
  logic              w_last;
  logic [ADDR_W-1:0] w_offset;

  assign w_issue  = (r_state == RUN);
  assign w_unary  = is_unary(r_opcode);
  assign w_last   = (r_cnt == (r_len - LEN_W'(1)));
  assign w_offset = ADDR_W'(r_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_opcode <= '0;
      r_src0   <= '0;
      r_src1   <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_opcode <= cmd_opcode;
            r_src0   <= cmd_src0_addr;
            r_src1   <= cmd_src1_addr;
            r_dst    <= cmd_dst_addr;
            r_len    <= cmd_len;
            r_cnt    <= '0;
            r_state  <= (cmd_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          // Stage 1 empty means the final element sits in stage 2 and writes now.
          if (!r_v1) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_wa1 <= '0;
      r_wa2 <= '0;
      r_op0 <= '0;
      r_op1 <= '0;
    end else begin
      r_v1  <= w_issue;
      r_wa1 <= r_dst + w_offset;
      r_v2  <= r_v1;
      r_wa2 <= r_wa1;
      if (r_v1) begin
        r_op0 <= rd0_data;
        r_op1 <= w_unary ? '0 : rd1_data;
      end
    end
  end

  assign cmd_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);

  assign rd0_en       = w_issue;
  assign rd1_en       = w_issue && !w_unary;
  assign rd0_addr     = rd0_en ? (r_src0 + w_offset) : '0;
  assign rd1_addr     = rd1_en ? (r_src1 + w_offset) : '0;

  assign vpu_start    = r_v2;
  assign vpu_opcode   = r_opcode;
  assign vpu_operand0 = r_op0;
  assign vpu_operand1 = r_op1;

  assign wr_en        = r_v2;
  assign wr_addr      = r_v2 ? r_wa2 : '0;
  assign wr_data      = vpu_result;

endmodule

`default_nettype wire

// File: tb/tb_vpu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_vpu_issue_ctrl
// Brief    : Bench for vpu_issue_ctrl with scratchpad, op-unit stand-in and model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vpu_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int OP_W   = 10;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_opcode = '0;
  logic [ADDR_W-1:0] cmd_src0_addr = '0;
  logic [ADDR_W-1:0] cmd_src1_addr = '0;
  logic [ADDR_W-1:0] cmd_dst_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              rd0_en, rd1_en;
  logic [ADDR_W-1:0] rd0_addr, rd1_addr;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              vpu_start;
  logic [OP_W-1:0]   vpu_opcode;
  logic [DATA_W-1:0] vpu_operand0, vpu_operand1, vpu_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, done;

  always #5 clk = ~clk;

  vpu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_src0_addr(cmd_src0_addr), .cmd_src1_addr(cmd_src1_addr),
    .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .vpu_start(vpu_start), .vpu_opcode(vpu_opcode),
    .vpu_operand0(vpu_operand0), .vpu_operand1(vpu_operand1), .vpu_result(vpu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // fp32 helpers via double precision; exact for the small-integer data used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fop(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      10'd0:   return r2f(f2r(a) + f2r(b));
      10'd1:   return r2f(f2r(a) - f2r(b));
      10'd2:   return a[31] ? 32'd0 : a;
      10'd3:   return r2f(f2r(a) * f2r(b));
      10'd4:   return (f2r(a) > 0.0) ? 32'h3F80_0000 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb vpu_result = fop(vpu_opcode, vpu_operand0, vpu_operand1);

  // Scratchpad: 1-cycle read latency, loader port used only during reset.
  logic [31:0] mem [1024];
  logic [31:0] rd0_q = '0, rd1_q = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (rd0_en) rd0_q <= mem[rd0_addr];
    if (rd1_en) rd1_q <= mem[rd1_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end
  assign rd0_data = rd0_q;
  assign rd1_data = rd1_q;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // Reference model: expected-write list plus read/done/ready cycle windows.
  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] op0;
    logic [31:0] op1;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mmem [1024];
  int          cyc = 0;
  int          ready_cyc = 0;
  int          done_cyc = -1;
  int          rd_first = 1;
  int          rd_last = 0;
  logic [9:0]  m_src0, m_src1, m_op;
  logic        m_unary = 1'b0;
  logic        m_ready, exp_rd, exp_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_accept(input int c);
    int          n;
    wr_t         w;
    logic [9:0]  a0, a1;
    n        = int'(cmd_len);
    m_op     = cmd_opcode;
    m_unary  = (cmd_opcode == 10'd2) || (cmd_opcode == 10'd4);
    m_src0   = cmd_src0_addr;
    m_src1   = cmd_src1_addr;
    rd_first = c + 1;
    rd_last  = c + n;
    for (int i = 0; i < n; i++) begin
      a0     = cmd_src0_addr + 10'(i);
      a1     = cmd_src1_addr + 10'(i);
      w.cyc  = c + 3 + i;
      w.addr = cmd_dst_addr + 10'(i);
      w.op0  = mmem[a0];
      w.op1  = m_unary ? 32'd0 : mmem[a1];
      w.data = fop(cmd_opcode, w.op0, w.op1);
      exp_q.push_back(w);
    end
    done_cyc  = (n == 0) ? c + 1 : c + n + 3;
    ready_cyc = done_cyc + 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (ld_en) mmem[ld_addr] = ld_data;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", {28'd0, rd0_en, rd1_en, wr_en, vpu_start}, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      exp_q.delete();
      ready_cyc = 0;
      done_cyc  = -1;
      rd_first  = 1;
      rd_last   = 0;
    end else begin
      m_ready = (cyc >= ready_cyc);
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(!m_ready));
      chk("done", 32'(done), 32'(cyc == done_cyc));
      exp_rd = (cyc >= rd_first) && (cyc <= rd_last);
      chk("rd0_en", 32'(rd0_en), 32'(exp_rd));
      chk("rd1_en", 32'(rd1_en), 32'(exp_rd && !m_unary));
      if (exp_rd) begin
        chk("rd0_addr", 32'(rd0_addr), 32'(10'(m_src0 + 10'(cyc - rd_first))));
        if (!m_unary) chk("rd1_addr", 32'(rd1_addr), 32'(10'(m_src1 + 10'(cyc - rd_first))));
      end
      exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wr_en", 32'(wr_en), 32'(exp_wr));
      chk("vpu_start", 32'(vpu_start), 32'(exp_wr));
      if (exp_wr) begin
        chk("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
        chk("wr_data", wr_data, exp_q[0].data);
        chk("operand0", vpu_operand0, exp_q[0].op0);
        chk("operand1", vpu_operand1, exp_q[0].op1);
        chk("vpu_opcode", 32'(vpu_opcode), 32'(m_op));
        mmem[exp_q[0].addr] = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      if (cmd_valid && m_ready) model_accept(cyc);
    end
  end

  task automatic issue(input logic [9:0] op, input logic [9:0] s0, input logic [9:0] s1,
                       input logic [9:0] d, input logic [9:0] len);
    int k;
    cmd_opcode    = op;
    cmd_src0_addr = s0;
    cmd_src1_addr = s1;
    cmd_dst_addr  = d;
    cmd_len       = len;
    cmd_valid     = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 300) timeout_fail("accept");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      if (cyc >= ready_cyc && exp_q.size() == 0) break;
    end
    if (k == 300) timeout_fail("idle");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_val(input int a);
    case (a)
      'h000: return 32'h3F80_0000;
      'h001: return 32'h4000_0000;
      'h002: return 32'h4040_0000;
      'h003: return 32'h4080_0000;
      'h010, 'h011, 'h012, 'h013: return 32'h4000_0000;
      'h040: return 32'hBF80_0000;
      'h041: return 32'h0000_0000;
      'h042: return 32'h4000_0000;
      'h050, 'h051: return 32'h4000_0000;
      'h060, 'h061: return 32'h4040_0000;
      'h070: return 32'h40A0_0000;
      'h080: return 32'h3F80_0000;
      'h3FE: return 32'h3F80_0000;
      'h3FF: return 32'h4000_0000;
      default: return r2f(real'(int'($urandom_range(0, 16)) - 8));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [9:0] op, s0, s1, d, len;
    int         r;
    for (int a = 0; a < 1024; a++) begin
      @(posedge clk);
      #1;
      ld_en   = 1'b1;
      ld_addr = 10'(a);
      ld_data = init_val(a);
    end
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(10'd0, 10'h000, 10'h010, 10'h020, 10'd4);   // ADD
    wait_idle();
    issue(10'd2, 10'h040, 10'h010, 10'h030, 10'd3);   // RELU
    wait_idle();
    issue(10'd1, 10'h050, 10'h060, 10'h0F0, 10'd0);   // len 0
    wait_idle();
    issue(10'd3, 10'h050, 10'h060, 10'h090, 10'd2);   // MUL, then SUB held valid
    issue(10'd1, 10'h070, 10'h080, 10'h0A0, 10'd1);
    wait_idle();
    issue(10'd0, 10'h3FE, 10'h010, 10'h3FF, 10'd3);   // address wrap
    wait_idle();

    issue(10'd0, 10'h100, 10'h180, 10'h3C0, 10'd8);   // abort by reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(10'd3, 10'h050, 10'h060, 10'h0B0, 10'd2);
    wait_idle();

    chk("mem_add0", mem[10'h020], 32'h4040_0000);
    chk("mem_add1", mem[10'h021], 32'h4080_0000);
    chk("mem_add2", mem[10'h022], 32'h40A0_0000);
    chk("mem_add3", mem[10'h023], 32'h40C0_0000);
    chk("mem_relu0", mem[10'h030], 32'h0000_0000);
    chk("mem_relu2", mem[10'h032], 32'h4000_0000);
    chk("mem_mul", mem[10'h090], 32'h40C0_0000);
    chk("mem_sub", mem[10'h0A0], 32'h4080_0000);
    chk("mem_wrap_3ff", mem[10'h3FF], 32'h4040_0000);
    chk("mem_wrap_000", mem[10'h000], 32'h4080_0000);
    chk("mem_wrap_001", mem[10'h001], 32'h4040_0000);
    chk("mem_abort", mem[10'h3C0], mmem[10'h3C0]);
    chk("mem_post_rst", mem[10'h0B1], 32'h40C0_0000);

    for (int n = 0; n < 40; n++) begin
      r   = int'($urandom_range(0, 5));
      op  = (r == 5) ? 10'd7 : 10'(r);
      len = 10'($urandom_range(0, 12));
      s0  = 10'h100 + 10'($urandom_range(0, 'h6F));
      s1  = 10'h180 + 10'($urandom_range(0, 'h6F));
      r   = int'($urandom_range(0, 3));
      d   = (r == 0) ? s0 : (r == 1) ? s1 : 10'h200 + 10'($urandom_range(0, 'hEF));
      issue(op, s0, s1, d, len);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vpu_issue_ctrl.md
Name: vpu_issue_ctrl

Overview:
Command-driven sequencer that drives the VPU ALU datapath element by element. It accepts one vector command (opcode, two source base addresses, destination base, length) and streams operand pairs out of the scratchpad on two 1-cycle-latency read ports. It presents each pair plus the opcode to the combinational VPU op unit, then writes each returned result back to the scratchpad. It sits between the host/instruction decoder and the VPU op unit, at one element per cycle.

Parameters:
DATA_W, 32, element width (fp32)
OP_W, 10, opcode width (matches VPU op unit)
ADDR_W, 10, scratchpad word-address width
LEN_W, 10, vector length field width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_opcode  in  OP_W  0 ADD, 1 SUB, 2 RELU, 3 MUL, 4 D_RELU
cmd_src0_addr  in  ADDR_W  operand0 base
cmd_src1_addr  in  ADDR_W  operand1 base
cmd_dst_addr  in  ADDR_W  result base
cmd_len  in  LEN_W  element count, 0 legal
rd0_en, rd1_en  out  1  read strobes
rd0_addr, rd1_addr  out  ADDR_W  read addresses
rd0_data, rd1_data  in  DATA_W  valid the cycle after the strobe
vpu_start  out  1  operands valid this cycle
vpu_opcode  out  OP_W  latched opcode
vpu_operand0, vpu_operand1  out  DATA_W  operand registers
vpu_result  in  DATA_W  combinational result from the VPU op unit
wr_en  out  1  write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  equals vpu_result
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse per completed command

Behaviour:
- Reset: state IDLE. All outputs 0 except cmd_ready = 1. Counters and pipeline valid bits cleared. Reset mid-command aborts with no further reads or writes and no done pulse.
- Handshake: the command is accepted on the clk edge with cmd_valid && cmd_ready. All cmd_* fields are latched at that edge. cmd_valid is ignored while busy.
- States: IDLE -> RUN on accept with len > 0; IDLE -> DONE on accept with len == 0. RUN -> DRAIN after the read for element len-1 is issued. DRAIN -> DONE once the last write is issued. DONE -> IDLE unconditionally after one cycle; done = 1 in DONE.
- Pipeline, for element i issued in cycle T:
  - Stage R (T): rd0/rd1 strobes with addresses src+i.
  - Stage O (T+1): rd data registered into vpu_operand0/1. vpu_start is valid in T+2.
  - Stage W (T+2): wr_en = 1, wr_addr = dst+i, wr_data = vpu_result, all combinational from the stage-O registers.
- Timing: the first read occurs the cycle after accept; one element per cycle; no bubbles. For len = N, element N-1 is written N+2 cycles after accept and done asserts the following cycle. A command with len = 0 produces done 1 cycle after accept. cmd_ready returns the cycle after done.
- vpu_start equals the stage-O valid bit. vpu_operand0/1 hold their last value when invalid.
- Unary ops: for opcodes 2 and 4, rd1_en stays 0 and vpu_operand1 is driven 0.
- Unknown opcodes are streamed unchanged. The VPU op unit returns 0, so zeros are written.
- Addresses: src+i and dst+i wrap modulo 2^ADDR_W. The element counter is LEN_W wide and never wraps within a command.
- In-place operation (dst == src0 or dst == src1) is supported, because element i is written after it is read. Other partial overlaps between destination and source ranges are undefined.

Decomposition:
- Shared package vpu_pkg holds:
  - opcode constants VPU_ADD = 0, VPU_SUB = 1, VPU_RELU = 2, VPU_MUL = 3, VPU_D_RELU = 4;
  - function is_unary(opcode);
  - state enum {IDLE, RUN, DRAIN, DONE}.
- No sub-module: the address counter and the 2-stage valid/address shift register stay inline. The VPU op unit is instantiated beside this block at the top level, not inside it.

Test Plan:
- ADD, len=4, src0=0x000 {1.0,2.0,3.0,4.0}, src1=0x010 all 2.0, dst=0x020 -> writes 0x40400000, 0x40800000, 0x40A00000, 0x40C00000 at 0x020..0x023 in consecutive cycles. First write 3 cycles after accept; done 1 cycle after the last write.
- RELU, len=3, src0={0xBF800000, 0x00000000, 0x40000000} -> writes {0, 0, 0x40000000}; rd1_en never asserts.
- len=0 accept -> no rd/wr strobes; done pulse 1 cycle after accept; cmd_ready high the cycle after.
- Back-to-back: MUL len=2, then SUB len=1 held valid -> second accept occurs exactly when cmd_ready returns; outputs 2.0*3.0 = 0x40C00000, then 5.0-1.0 = 0x40800000 at correct addresses; the fields of the second command do not corrupt the first.
- Wrap: src0=0x3FE, dst=0x3FF, len=3 with ADDR_W=10 -> reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
- Assert rst 2 cycles into a len=8 command -> all strobes drop immediately, busy=0, cmd_ready=1, no done pulse; the next command runs correctly.
